fetch_stage: RTL and testbench

- Fetch-stage control: PC register, next-PC selection, and the IF/ID pipeline register of the 5-stage RV32I pipeline.
- Drives the word address into the combinational instruction memory. Captures the returned instruction into IF/ID for decode.
- Obeys stall/flush from the hazard unit and branch/jump redirects from EX.

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage RV32I pipeline: PC register, next-PC selection and IF/ID register.
// pc_f is the only output that is not an IF/ID or status register, and it is still registered.
module fetch_stage #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0]      NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     misalign_err,
    output logic [31:0]              fetch_count
);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0]    r_instr_d;
    logic [ADDRESS_WIDTH-1:0] r_pc_d;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4_d;
    logic                     r_valid_d;
    logic                     r_misalign;
    logic [31:0]              r_fetch_count;

    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_target_aligned;

    assign w_pc_plus4       = r_pc + ADDRESS_WIDTH'(4);
    assign w_target_aligned = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= '0;
            r_pc_plus4_d  <= '0;
            r_valid_d     <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            // A redirect beats stall_f: the stalled fetch is on the wrong path anyway.
            if (pc_src_e) begin
                r_pc <= w_target_aligned;
            end else if (!stall_f) begin
                r_pc <= w_pc_plus4;
            end

            if (pc_src_e && (pc_target_e[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end

            if (flush_d) begin
                r_instr_d    <= NOP_INSTR;
                r_pc_d       <= '0;
                r_pc_plus4_d <= '0;
                r_valid_d    <= 1'b0;
            end else if (!stall_d) begin
                r_instr_d     <= instr_f;
                r_pc_d        <= r_pc;
                r_pc_plus4_d  <= w_pc_plus4;
                r_valid_d     <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign pc_f         = r_pc;
    assign instr_d      = r_instr_d;
    assign pc_d         = r_pc_d;
    assign pc_plus4_d   = r_pc_plus4_d;
    assign valid_d      = r_valid_d;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random stimulus,
// all outputs compared every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
    logic        m_v, m_mis;

    always #5 clk = ~clk;

    // Instruction memory: word at address a holds 0xA0 + a.
    assign instr_f = 32'hA0 + pc_f;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .pc_target_e  (pc_target_e),
        .instr_f      (instr_f),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge, applied with the inputs currently driven.
    task automatic model_edge();
        logic [31:0] seq;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_v = 0; m_mis = 0; m_cnt = 0;
        end else begin
            seq = m_pc + 32'd4;
            if (flush_d) begin
                m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_v = 0;
            end else if (!stall_d) begin
                m_instr = 32'hA0 + m_pc; m_pcd = m_pc; m_p4 = seq; m_v = 1; m_cnt = m_cnt + 1;
            end
            if (pc_src_e && pc_target_e[1:0] != 2'b00) m_mis = 1;
            if (pc_src_e)      m_pc = pc_target_e & 32'hFFFF_FFFC;
            else if (!stall_f) m_pc = seq;
        end
    endtask

    task automatic cyc(input bit r, input bit sf, input bit sd, input bit fd, input bit src,
                       input logic [31:0] tgt);
        rst = r; stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = src; pc_target_e = tgt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_f", pc_f, m_pc);
            chk("instr_d", instr_d, m_instr);
            chk("pc_d", pc_d, m_pcd);
            chk("pc_plus4_d", pc_plus4_d, m_p4);
            chk("valid_d", {31'b0, valid_d}, {31'b0, m_v});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    initial begin
        rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        chk("lit_rst_pc", pc_f, 32'h0);
        chk("lit_rst_instr", instr_d, 32'h13);
        chk("lit_rst_valid", {31'b0, valid_d}, 32'h0);

        // Free run
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_run1_instr", instr_d, 32'hA0);
        chk("lit_run1_valid", {31'b0, valid_d}, 32'h1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_run2_pc", pc_f, 32'h8);
        chk("lit_run2_instr", instr_d, 32'hA4);

        // Stall both for two cycles at pc_f=8
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lit_stall_pc", pc_f, 32'h8);
        chk("lit_stall_pcd", pc_d, 32'h4);
        chk("lit_stall_cnt", fetch_count, 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_resume_pc", pc_f, 32'hC);
        chk("lit_resume_instr", instr_d, 32'hA8);
        chk("lit_resume_cnt", fetch_count, 32'd3);

        // Redirect with flush while stall_f is held
        cyc(0, 1, 0, 1, 1, 32'h40);
        chk("lit_redir_pc", pc_f, 32'h40);
        chk("lit_redir_instr", instr_d, 32'h13);
        chk("lit_redir_valid", {31'b0, valid_d}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_redir_instr2", instr_d, 32'hE0);
        chk("lit_redir_pcd", pc_d, 32'h40);
        chk("lit_redir_p4", pc_plus4_d, 32'h44);

        // Flush beats stall_d
        cyc(0, 0, 1, 1, 0, 0);
        chk("lit_flushstall_valid", {31'b0, valid_d}, 32'h0);
        chk("lit_flushstall_instr", instr_d, 32'h13);

        // Misaligned redirect
        cyc(0, 0, 0, 1, 1, 32'h43);
        chk("lit_mis_pc", pc_f, 32'h40);
        chk("lit_mis_flag", {31'b0, misalign_err}, 32'h1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("lit_mis_sticky", {31'b0, misalign_err}, 32'h1);

        // PC wrap
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        chk("lit_wrap_pc0", pc_f, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_wrap_pc1", pc_f, 32'h0);
        chk("lit_wrap_p4", pc_plus4_d, 32'h0);
        chk("lit_wrap_instr", instr_d, 32'h9C);

        // Reset during a stall
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("lit_rststall_pc", pc_f, 32'h0);
        chk("lit_rststall_valid", {31'b0, valid_d}, 32'h0);
        chk("lit_rststall_cnt", fetch_count, 32'h0);
        chk("lit_rststall_mis", {31'b0, misalign_err}, 32'h0);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 6) == 0,
                $urandom_range(0, 7) == 0,
                t);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
